fetch_unit: RTL and testbench

Instruction fetch stage: owns the 36-bit program counter, drives the instruction-memory request, and presents `inst`, `pc`, `pc_plus_4`, `vread1` and `vread2` to the fetch/decode pipeline register. It handles memory-not-ready wait cycles, branch/jump redirects from execute, and halt detection. It also counts retired fetches. All outputs toward fetch/decode are combinational; that register does the capturing.

---
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the 36-bit PC and drives the instruction-memory request. Presents a
// combinational inst/pc bundle to the fetch/decode register, and handles
// memory wait cycles, execute-stage redirects and halt detection.
module fetch_unit #(
  parameter logic [35:0] RESET_PC    = 36'h0,
  parameter logic [31:0] NOP_INST    = 32'h0800_0000,
  parameter logic [6:0]  HALT_OPCODE = 7'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [35:0] redirect_pc,
  output logic        imem_req,
  output logic [35:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] inst,
  output logic [35:0] pc,
  output logic [35:0] pc_plus_4,
  output logic [4:0]  vread1,
  output logic [4:0]  vread2,
  output logic        halted,
  output logic        miss,
  output logic [31:0] inst_count
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_MISS = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state;
  logic [35:0] pc_q;
  logic [31:0] cnt_q;
  logic        accept;
  logic        is_halt_op;
  logic        bubble;

  assign is_halt_op = (imem_rdata[31:25] == HALT_OPCODE);
  assign accept     = !redirect && !stall && (state != S_HALT) && imem_valid;

  // PC, instruction counter and fetch state; redirect outranks everything but reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
      state <= S_RUN;
    end else if (redirect) begin
      pc_q  <= {redirect_pc[35:2], 2'b00};
      state <= S_RUN;
    end else if (state == S_HALT) begin
      state <= S_HALT;
    end else if (stall) begin
      state <= state;
    end else if (!imem_valid) begin
      state <= S_MISS;
    end else if (accept) begin
      pc_q  <= pc_q + 36'd4;
      cnt_q <= cnt_q + 32'd1;
      state <= is_halt_op ? S_HALT : S_RUN;
    end
  end

  // Squash to NOP on redirect, halt, memory not ready, or while reset is held
  assign bubble = rst || redirect || (state == S_HALT) || !imem_valid;

  // Outputs toward fetch/decode and instruction memory
  always_comb begin
    inst       = bubble ? NOP_INST : imem_rdata;
    vread1     = inst[19:15];
    vread2     = inst[14:10];
    pc         = pc_q;
    pc_plus_4  = pc_q + 36'd4;
    imem_addr  = pc_q;
    imem_req   = !rst && (state != S_HALT);
    halted     = (state == S_HALT);
    miss       = (state == S_MISS);
    inst_count = cnt_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic for fetch_unit,
// checked against a behavioural model of the fetch rules.
module tb_fetch_unit;

  localparam logic [35:0] RPC  = 36'h100;
  localparam logic [31:0] NOP  = 32'h0800_0000;
  localparam logic [6:0]  HOP  = 7'h01;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [35:0] redirect_pc;
  logic        imem_req;
  logic [35:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] inst;
  logic [35:0] pc;
  logic [35:0] pc_plus_4;
  logic [4:0]  vread1;
  logic [4:0]  vread2;
  logic        halted;
  logic        miss;
  logic [31:0] inst_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model: architectural view of the fetch stage
  logic [35:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_halted;
  bit          m_waiting;

  fetch_unit #(
    .RESET_PC   (RPC),
    .NOP_INST   (NOP),
    .HALT_OPCODE(HOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .inst       (inst),
    .pc         (pc),
    .pc_plus_4  (pc_plus_4),
    .vread1     (vread1),
    .vread2     (vread2),
    .halted     (halted),
    .miss       (miss),
    .inst_count (inst_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc      = RPC;
    m_cnt     = 0;
    m_halted  = 0;
    m_waiting = 0;
  endtask

  // Expected combinational outputs from model state and current inputs
  task automatic check_outputs();
    logic [31:0] e_inst;
    if (rst || redirect || m_halted || !imem_valid) e_inst = NOP;
    else e_inst = imem_rdata;
    check("inst",       64'(inst),       64'(e_inst));
    check("vread1",     64'(vread1),     64'((e_inst >> 15) & 32'h1f));
    check("vread2",     64'(vread2),     64'((e_inst >> 10) & 32'h1f));
    check("pc",         64'(pc),         64'(m_pc));
    check("imem_addr",  64'(imem_addr),  64'(m_pc));
    check("pc_plus_4",  64'(pc_plus_4),  64'((m_pc + 36'd4) % (64'd1 << 36)));
    check("imem_req",   64'(imem_req),   64'(!rst && !m_halted));
    check("halted",     64'(halted),     64'(m_halted));
    check("miss",       64'(miss),       64'(m_waiting));
    check("inst_count", 64'(inst_count), 64'(m_cnt));
  endtask

  // Apply the next-cycle rules to the model using the inputs held over the edge
  task automatic model_advance();
    if (rst) model_reset();
    else if (redirect) begin
      m_pc      = redirect_pc & ~36'd3;
      m_halted  = 0;
      m_waiting = 0;
    end else if (m_halted || stall) begin
      // hold
    end else if (!imem_valid) begin
      m_waiting = 1;
    end else begin
      m_pc      = m_pc + 36'd4;
      m_cnt     = m_cnt + 32'd1;
      m_halted  = (imem_rdata[31:25] == HOP);
      m_waiting = 0;
    end
  endtask

  // One cycle: drive inputs after the falling edge, check, then cross the rising edge
  task automatic step(input logic [31:0] rd, input logic v, input logic s,
                      input logic r, input logic [35:0] rp);
    imem_rdata  = rd;
    imem_valid  = v;
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    #1;
    check_outputs();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  function automatic logic [31:0] plain_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:25] == HOP) w[31:25] = 7'h22;
    return w;
  endfunction

  initial begin
    logic [31:0] w;
    logic [31:0] hw;
    hw = {HOP, 25'h0};

    rst = 1'b1; stall = 0; redirect = 0; redirect_pc = '0;
    imem_rdata = 32'h1234_5678; imem_valid = 1'b1;
    model_reset();
    @(negedge clk);
    step(32'h1234_5678, 1, 0, 0, '0);   // reset values while rst high
    rst = 1'b0;

    // Reset then run: three instructions from 0x100
    for (int i = 0; i < 3; i++) step(plain_word(), 1, 0, 0, '0);
    check("run_pc", 64'(pc), 64'h10c);
    check("run_cnt", 64'(inst_count), 64'd3);

    // Memory wait at 0x104 for two cycles
    step(plain_word(), 0, 0, 1, 36'h104);
    step(plain_word(), 0, 0, 0, '0);
    step(plain_word(), 0, 0, 0, '0);
    check("wait_pc", 64'(pc), 64'h104);
    check("wait_miss", 64'(miss), 64'd1);
    step(plain_word(), 1, 0, 0, '0);
    check("resume_pc", 64'(pc), 64'h108);

    // Redirect while stalled and missing, unaligned target
    step(plain_word(), 0, 0, 0, '0);
    step(plain_word(), 0, 1, 1, 36'h2002);
    check("redir_pc", 64'(pc), 64'h2000);
    check("redir_miss", 64'(miss), 64'd0);

    // Stall with valid data: same address re-presented
    step(plain_word(), 1, 1, 0, '0);
    check("stall_pc", 64'(pc), 64'h2000);

    // Halt at 0x40, then redirect out to 0x80
    step(plain_word(), 1, 0, 1, 36'h40);
    step(hw, 1, 0, 0, '0);
    step(plain_word(), 1, 0, 0, '0);
    check("halt_pc", 64'(pc), 64'h44);
    check("halt_flag", 64'(halted), 64'd1);
    step(plain_word(), 1, 0, 1, 36'h80);
    check("unhalt_pc", 64'(pc), 64'h80);
    check("unhalt_flag", 64'(halted), 64'd0);

    // Halt opcode together with redirect: redirect wins
    w = inst_count;
    step(hw, 1, 0, 1, 36'h300);
    check("hr_halted", 64'(halted), 64'd0);
    check("hr_cnt", 64'(inst_count), 64'(m_cnt));

    // Asynchronous reset mid-miss
    step(plain_word(), 0, 0, 0, '0);
    imem_valid = 1'b1;
    rst = 1'b1;
    #1;
    check("arst_pc", 64'(pc), 64'(RPC));
    check("arst_miss", 64'(miss), 64'd0);
    check("arst_req", 64'(imem_req), 64'd0);
    check("arst_inst", 64'(inst), 64'(NOP));
    model_reset();
    step(plain_word(), 1, 0, 0, '0);
    rst = 1'b0;

    // PC wrap at the top of the address space
    step(plain_word(), 1, 0, 1, 36'hF_FFFF_FFFE);
    check("wrap_pc4", 64'(pc_plus_4), 64'd0);
    step(plain_word(), 1, 0, 0, '0);
    check("wrap_pc", 64'(pc), 64'd0);

    // Counter wrap from a preloaded value
    force dut.cnt_q = 32'hFFFF_FFFE;
    release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    step(plain_word(), 1, 0, 0, '0);
    step(plain_word(), 1, 0, 0, '0);
    check("cnt_wrap", 64'(inst_count), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      w = ($urandom_range(0, 7) == 0) ? {HOP, 25'($urandom)} : plain_word();
      step(w, ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 9) == 0), {4'($urandom), 32'($urandom)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
